// File: rtl/aap_fetch_issue_ctrl_pkg.sv
// Shared definitions for the AAP fetch/issue controller: FSM states,
// instruction length codes and the 32-bit-instruction flag positions.
package aap_fetch_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        SECOND = 2'd1,
        ISSUE  = 2'd2
    } fetch_state_e;

    localparam logic ISSUE_LEN16 = 1'b0;
    localparam logic ISSUE_LEN32 = 1'b1;

    // Flag marking a 32-bit instruction: bit 15 of its first parcel,
    // which lands in bit 31 of the decoder word.
    localparam int unsigned PARCEL_FLAG_BIT = 15;
    localparam int unsigned WORD_FLAG_BIT   = 31;

    function automatic logic is_32bit_parcel(input logic [15:0] parcel);
        return parcel[PARCEL_FLAG_BIT];
    endfunction

endpackage

// File: rtl/aap_fetch_issue_ctrl_perf_counters.sv
// Saturating 32-bit performance counters for the fetch/issue controller:
// issued 16-bit instructions, issued 32-bit instructions, issue stall cycles.
// Only instantiated when AAP_FETCH_PERF_COUNT_EN is defined.
module aap_fetch_perf_counters
    import aap_fetch_issue_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_ready,
    input  logic        issue_len,
    output logic [31:0] perf_issued16,
    output logic [31:0] perf_issued32,
    output logic [31:0] perf_stall
);

    logic [31:0] r_issued16;
    logic [31:0] r_issued32;
    logic [31:0] r_stall;
    logic        w_handshake;

    assign w_handshake = issue_valid & issue_ready;

    // Count handshakes by length and stalled issue cycles, holding at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issued16 <= '0;
            r_issued32 <= '0;
            r_stall    <= '0;
        end else begin
            if (w_handshake && (issue_len == ISSUE_LEN16) && (r_issued16 != '1))
                r_issued16 <= r_issued16 + 32'd1;
            if (w_handshake && (issue_len == ISSUE_LEN32) && (r_issued32 != '1))
                r_issued32 <= r_issued32 + 32'd1;
            if (issue_valid && !issue_ready && (r_stall != '1))
                r_stall <= r_stall + 32'd1;
        end
    end

    assign perf_issued16 = r_issued16;
    assign perf_issued32 = r_issued32;
    assign perf_stall    = r_stall;

endmodule

// File: rtl/aap_fetch_issue_ctrl.sv
// AAP instruction fetch/issue controller. Fetches 16-bit parcels over a
// req/ack memory handshake, assembles 16/32-bit instructions into the
// decoder word and issues them over valid/ready. Owns the PC and handles
// redirect (highest priority) and halt.
// Optional: define AAP_FETCH_PERF_COUNT_EN to add perf_issued16,
// perf_issued32 and perf_stall counter outputs.
module aap_fetch_issue_ctrl
    import aap_fetch_issue_ctrl_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 24,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic                issue_valid,
    input  logic                issue_ready,
`ifdef AAP_FETCH_PERF_COUNT_EN
    output logic [31:0]         perf_issued16,
    output logic [31:0]         perf_issued32,
    output logic [31:0]         perf_stall,
`endif
    output logic [31:0]         fetchoutput,
    output logic [PC_WIDTH-1:0] issue_pc,
    output logic                issue_len
);

    fetch_state_e        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_imem_req;
    logic [PC_WIDTH-1:0] r_imem_addr;
    logic                r_issue_valid;
    logic [31:0]         r_fetchoutput;
    logic [PC_WIDTH-1:0] r_issue_pc;
    logic                r_issue_len;

    logic [PC_WIDTH-1:0] w_pc_plus1;
    logic [PC_WIDTH-1:0] w_pc_next;

    assign w_pc_plus1 = r_pc + PC_WIDTH'(1);
    assign w_pc_next  = r_pc + PC_WIDTH'(1) + PC_WIDTH'(r_issue_len);

    // Fetch/issue FSM with registered memory and issue outputs. The request
    // is armed one cycle after entering FIRST (or at the issue handshake),
    // which is where halt is sampled; once raised it is held until ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FIRST;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_issue_valid <= 1'b0;
            r_fetchoutput <= '0;
            r_issue_pc    <= RESET_PC;
            r_issue_len   <= ISSUE_LEN16;
        end else if (redirect_valid) begin
            r_state       <= FIRST;
            r_pc          <= redirect_pc;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= redirect_pc;
            r_issue_valid <= 1'b0;
        end else begin
            case (r_state)
                FIRST: begin
                    if (!r_imem_req) begin
                        r_imem_req <= !halt;
                    end else if (imem_ack) begin
                        r_fetchoutput[31:16] <= imem_rdata;
                        if (is_32bit_parcel(imem_rdata)) begin
                            r_imem_addr <= w_pc_plus1;
                            r_state     <= SECOND;
                        end else begin
                            r_fetchoutput[15:0] <= '0;
                            r_issue_len         <= ISSUE_LEN16;
                            r_issue_pc          <= r_pc;
                            r_imem_req          <= 1'b0;
                            r_issue_valid       <= 1'b1;
                            r_state             <= ISSUE;
                        end
                    end
                end
                SECOND: begin
                    if (imem_ack) begin
                        r_fetchoutput[15:0] <= imem_rdata;
                        r_issue_len         <= ISSUE_LEN32;
                        r_issue_pc          <= r_pc;
                        r_imem_req          <= 1'b0;
                        r_issue_valid       <= 1'b1;
                        r_state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        r_issue_valid <= 1'b0;
                        r_pc          <= w_pc_next;
                        r_imem_addr   <= w_pc_next;
                        r_imem_req    <= !halt;
                        r_state       <= FIRST;
                    end
                end
                default: begin
                    r_state <= FIRST;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign issue_valid = r_issue_valid;
    assign fetchoutput = r_fetchoutput;
    assign issue_pc    = r_issue_pc;
    assign issue_len   = r_issue_len;

`ifdef AAP_FETCH_PERF_COUNT_EN
    aap_fetch_perf_counters u_perf (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (r_issue_valid),
        .issue_ready   (issue_ready),
        .issue_len     (r_issue_len),
        .perf_issued16 (perf_issued16),
        .perf_issued32 (perf_issued32),
        .perf_stall    (perf_stall)
    );
`endif

endmodule

// File: doc/aap_fetch_issue_ctrl.md
Name: aap_fetch_issue_ctrl

Overview:
- Sequences instruction fetch for the AAP pipeline and feeds the instruction decoder.
- Reads 16-bit parcels from instruction memory over a req/ack handshake.
- Assembles 16-bit or 32-bit instructions into the 32-bit decoder input word (bit 31 = 32-bit flag) and presents them to decode/execute with a valid/ready handshake.
- Owns the PC and handles branch redirect (flush) and halt.

Parameters:
- PC_WIDTH, 24, width of PC and parcel address; addresses count 16-bit parcels.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- halt  input  1  when high, no new instruction fetch is started.
- redirect_valid  input  1  branch/flush request, one-cycle pulse.
- redirect_pc  input  PC_WIDTH  new PC for redirect.
- imem_req  output  1  parcel read request.
- imem_addr  output  PC_WIDTH  parcel address.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  16  parcel data.
- issue_valid  output  1  fetchoutput/issue_pc/issue_len valid.
- issue_ready  input  1  decoder/execute accepts instruction.
- fetchoutput  output  32  decoder input word.
- issue_pc  output  PC_WIDTH  PC of the issued instruction.
- issue_len  output  1  0 = 16-bit, 1 = 32-bit.

Behaviour:
- Reset values: state FIRST, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, issue_valid=0, fetchoutput=0, issue_pc=RESET_PC, issue_len=0.
- States:
  - FIRST: imem_req=!halt, imem_addr=pc. On ack, latch rdata into fetchoutput[31:16]. If rdata[15]=0: fetchoutput[15:0]=0, issue_len=0, go to ISSUE. If rdata[15]=1: go to SECOND.
  - SECOND: imem_req=1, imem_addr=pc+1 (mod 2^PC_WIDTH). On ack: fetchoutput[15:0]=rdata, issue_len=1, go to ISSUE.
  - ISSUE: issue_valid=1, imem_req=0; outputs are held stable until issue_ready. On handshake: pc = pc+1+issue_len (wraps modulo 2^PC_WIDTH), go to FIRST.
- imem_req and imem_addr are held stable while awaiting ack. The memory may take any number of cycles to ack.
- Latency with zero-wait memory and issue_ready held high:
  - 16-bit instruction: 2 cycles per instruction.
  - 32-bit instruction: 3 cycles per instruction.
  - issue_valid rises the cycle after the final ack.
- Halt:
  - Sampled only in FIRST before a request is raised; a request already outstanding completes.
  - Halt does not suppress SECOND or ISSUE.
- Redirect has the highest priority, in any state:
  - next cycle: pc=redirect_pc, state FIRST, issue_valid=0.
  - An ack arriving in the redirect cycle is discarded.
  - An issue handshake occurring in the redirect cycle still counts as consumed; pc takes redirect_pc, not the incremented value.
  - An outstanding imem request is dropped in the next cycle. The memory must tolerate req deassertion without ack.
- Reset mid-operation: immediate return to reset values. Partial instructions are discarded.

Optional Feature:
- Macro: AAP_FETCH_PERF_COUNT_EN.
- Defined: adds three outputs, each 32 bits, saturating, zeroed on reset:
  - perf_issued16: counts issue handshakes with issue_len=0.
  - perf_issued32: counts issue handshakes with issue_len=1.
  - perf_stall: counts cycles with issue_valid=1 and issue_ready=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding constants FIRST=2'd0, SECOND=2'd1, ISSUE=2'd2;
  - ISSUE_LEN16/ISSUE_LEN32;
  - the 32-bit-flag bit index (15 within a parcel, 31 within fetchoutput).
- One natural sub-module: aap_fetch_perf_counters, instantiated only under the macro.

Test Plan:
- Reset RESET_PC=0x000010, memory returns 0x1234 at 0x10 with zero wait, issue_ready=1 -> imem_addr=0x10; fetchoutput=0x12340000, issue_len=0, issue_pc=0x10; next imem_addr=0x11.
- Parcels 0x8A01 @0x20, 0x5C3F @0x21 -> fetchoutput=0x8A015C3F, issue_len=1, issue_pc=0x20; next fetch at 0x22.
- Hold issue_ready=0 for 5 cycles during ISSUE -> issue_valid and fetchoutput stable, no imem_req; with the macro defined, perf_stall=5.
- redirect_valid with redirect_pc=0x400 while in SECOND with ack the same cycle -> ack discarded; next cycle imem_addr=0x400 in FIRST; no issue_valid for the aborted instruction.
- 32-bit instruction at pc=0xFFFFFF (PC_WIDTH=24) -> second parcel fetched from 0x000000; post-issue pc=0x000001.
- halt=1 in FIRST -> imem_req stays 0; deassert halt -> request at the same pc. Assert reset_n=0 mid-SECOND -> all outputs return to reset values asynchronously.
